// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between a fetch port and a data port
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);
  localparam int SW = MAX_DSTREAK > 0 ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic forced, timeout;
  // a data grant with i_req pending implies streak < MAX_DSTREAK, so the increment never overflows
  assign forced = i_req && streak == SW'(MAX_DSTREAK);
  assign timeout = TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      streak <= '0;
      tcnt <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      m_req <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (d_req && !forced) begin
            state <= DBUSY;
            m_req <= 1'b1;
            m_we <= d_we;
            m_addr <= d_addr;
            m_wdata <= d_wdata;
            tcnt <= '0;
            streak <= i_req ? streak + SW'(1) : '0;
          end else if (i_req) begin
            state <= IBUSY;
            m_req <= 1'b1;
            m_we <= 1'b0;
            m_addr <= i_addr;
            tcnt <= '0;
            streak <= '0;
          end
        IBUSY, DBUSY:
          if (m_ready || timeout) begin
            state <= DONE;
            m_req <= 1'b0;
            err <= !m_ready;
            i_ack <= state == IBUSY;
            d_ack <= state == DBUSY;
            if (m_ready && state == IBUSY) i_rdata <= m_rdata;
            if (m_ready && state == DBUSY && !m_we) d_rdata <= m_rdata;
          end else tcnt <= tcnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, wait states, timeout and async reset
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic i_ack, d_ack, m_req, m_we, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  int nvec = 0;
  int nerr = 0;
  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    {i_req, d_req, d_we, m_ready} = '0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    m_rdata = '0;
    tick;
    tick;
    chk("rst_ctl", {27'd0, m_req, m_we, i_ack, d_ack, err}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata | m_wdata, 32'd0);
    reset = 1'b1;
    tick;
    // fetch only, memory always ready
    i_req = 1'b1;
    i_addr = 32'h10;
    m_ready = 1'b1;
    m_rdata = 32'h03A03002;
    tick;
    chk("f_mreq", {31'd0, m_req}, 32'd1);
    chk("f_maddr", m_addr, 32'h10);
    chk("f_mwe", {31'd0, m_we}, 32'd0);
    chk("f_noack", {31'd0, i_ack}, 32'd0);
    tick;
    chk("f_ack", {30'd0, i_ack, d_ack}, 32'b10);
    chk("f_rdata", i_rdata, 32'h03A03002);
    chk("f_mreq_drop", {31'd0, m_req}, 32'd0);
    tick;
    chk("f_done", {30'd0, i_ack, m_req}, 32'd0);
    tick;
    chk("f_regrant", {31'd0, m_req}, 32'd1);
    i_req = 1'b0;
    m_rdata = 32'h1111;
    tick;
    chk("f_viol_ack", {31'd0, i_ack}, 32'd1);
    chk("f_viol_rdata", i_rdata, 32'h1111);
    tick;
    // store then load
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'd5;
    tick;
    chk("st_mctl", {30'd0, m_req, m_we}, 32'b11);
    chk("st_maddr", m_addr, 32'h20);
    chk("st_mwdata", m_wdata, 32'd5);
    m_rdata = 32'hDEAD;
    tick;
    chk("st_ack", {30'd0, d_ack, err}, 32'b10);
    chk("st_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick;
    d_req = 1'b1;
    d_we = 1'b0;
    m_rdata = 32'd5;
    tick;
    chk("ld_mctl", {30'd0, m_req, m_we}, 32'b10);
    tick;
    chk("ld_ack", {31'd0, d_ack}, 32'd1);
    chk("ld_rdata", d_rdata, 32'd5);
    d_req = 1'b0;
    tick;
    // wait states: ready arrives after three idle cycles of m_req
    d_req = 1'b1;
    d_addr = 32'h40;
    m_ready = 1'b0;
    m_rdata = 32'h77;
    for (int k = 1; k <= 4; k++) begin
      tick;
      chk("ws_hold", {m_req, d_ack, 30'd0} ^ m_addr, {2'b10, 30'd0} ^ 32'h40);
    end
    m_ready = 1'b1;
    tick;
    chk("ws_ack", {30'd0, d_ack, m_req}, 32'b10);
    chk("ws_rdata", d_rdata, 32'h77);
    d_req = 1'b0;
    tick;
    // contention: both held, expect D,D,D,D,I repeating
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 32'h100;
    d_addr = 32'h200;
    m_rdata = 32'hC0DE;
    for (int n = 0; n < 10; n++) begin
      tick;
      chk("ct_grant", m_addr, (n % 5 == 4) ? 32'h100 : 32'h200);
      tick;
      chk("ct_ack", {30'd0, i_ack, d_ack}, (n % 5 == 4) ? 32'b10 : 32'b01);
      tick;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("ct_rdata", d_rdata, 32'hC0DE);
    tick;
    // timeout with memory never ready
    d_req = 1'b1;
    d_addr = 32'h300;
    m_ready = 1'b0;
    m_rdata = 32'hBAD;
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk("to_wait", {30'd0, m_req, d_ack}, 32'b10);
    end
    tick;
    chk("to_ack_err", {29'd0, d_ack, err, m_req}, 32'b110);
    chk("to_rdata", d_rdata, 32'hC0DE);
    d_req = 1'b0;
    tick;
    chk("to_err_pulse", {30'd0, err, d_ack}, 32'd0);
    // async reset mid-transaction
    i_req = 1'b1;
    i_addr = 32'h500;
    tick;
    chk("ar_mreq", {31'd0, m_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_drop", {30'd0, m_req, i_ack}, 32'd0);
    chk("ar_maddr", m_addr, 32'd0);
    tick;
    chk("ar_noack", {31'd0, i_ack}, 32'd0);
    reset = 1'b1;
    m_ready = 1'b1;
    m_rdata = 32'h5A5A;
    tick;
    chk("ar_regrant", {m_req, 31'd0} | m_addr, 32'h80000500);
    tick;
    chk("ar_ack", {31'd0, i_ack}, 32'd1);
    chk("ar_rdata", i_rdata, 32'h5A5A);
    i_req = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
